// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction size and the canonical NOP word.
`timescale 1ns/1ps

package fetch_unit_pkg;

    // Fetch FSM states; the encoding is private to the fetch unit.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding (or about to be) for req_addr
        ST_HOLD  = 2'd1,  // IR holds a word waiting for the decoder
        ST_DRAIN = 2'd2   // waiting out a request abandoned by a redirect
    } fetch_state_e;

    localparam logic [31:0] INSN_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time, latches
// the returned word into IR and holds it until the decoder accepts it.
// Redirects always win; a redirect that arrives while a request is still
// outstanding lets that request drain and drops its data.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds fetch_misaligned /
// fetch_bad_pc and stops fetching after a misaligned redirect target.
`timescale 1ns/1ps

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_bad_pc
`endif
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_addr_q;
    logic [31:0]  ir_q;
    logic [31:0]  ir_pc_q;
    logic         ir_valid_q;

    logic [31:0]  redirect_target;
    logic         fetch_halted;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic         misaligned_q;
    logic [31:0]  bad_pc_q;
    logic         redirect_bad;

    assign redirect_target  = redirect_pc;
    assign redirect_bad     = (redirect_pc[1:0] != 2'b00);
    assign fetch_halted     = misaligned_q;
    assign fetch_misaligned = misaligned_q;
    assign fetch_bad_pc     = bad_pc_q;

    // Misalignment flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
            bad_pc_q     <= 32'h0;
        end else if (redirect) begin
            misaligned_q <= redirect_bad;
            if (redirect_bad) begin
                bad_pc_q <= redirect_pc;
            end
        end
    end
`else
    logic unused_redirect_lsb;

    // Without the checker the low address bits are simply forced to zero.
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fetch_halted        = 1'b0;
`endif

    // Request is live in FETCH (unless halted) and always in DRAIN, since the
    // drained request was already on the bus. Reset masks it immediately.
    assign imem_req  = !rst && ((state_q == ST_DRAIN) ||
                                ((state_q == ST_FETCH) && !fetch_halted));
    assign imem_addr = req_addr_q;
    assign IR        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;

    // Fetch FSM with its datapath registers; redirect has priority everywhere.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values and the block order cannot change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            ir_q       <= 32'h0;
            ir_pc_q    <= 32'h0;
            ir_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (redirect) begin
                        pc_q       <= redirect_target;
                        ir_valid_q <= 1'b0;
                        if (imem_req && !imem_ack) begin
                            // Keep the old address on the bus until it is acked.
                            state_q <= ST_DRAIN;
                        end else begin
                            req_addr_q <= redirect_target;
                            state_q    <= ST_FETCH;
                        end
                    end else if (imem_req && imem_ack) begin
                        ir_q       <= imem_rdata;
                        ir_pc_q    <= req_addr_q;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_q + INSN_BYTES;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc_q       <= redirect_target;
                        req_addr_q <= redirect_target;
                        ir_valid_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end else if (ir_ready) begin
                        ir_valid_q <= 1'b0;
                        req_addr_q <= pc_q;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        pc_q       <= redirect_target;
                        ir_valid_q <= 1'b0;
                    end else if (imem_ack) begin
                        // Stale data is dropped; start the redirected stream.
                        req_addr_q <= pc_q;
                        state_q    <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC = 0x100).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
    logic [31:0] fetch_bad_pc;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IR          (IR),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned),
        .fetch_bad_pc     (fetch_bad_pc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the directed sequence is a few dozen cycles long.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] hold_ir;
        logic [31:0] wrap_rpc;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();

        // Reset state
        check("rst_req",      {31'b0, imem_req}, 32'd0);
        check("rst_addr",     imem_addr, 32'h100);
        check("rst_ir",       IR, 32'h0);
        check("rst_ir_pc",    ir_pc, 32'h0);
        check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);

        // First request in the first cycle out of reset, zero-wait memory
        rst = 1'b0;
        #1;
        check("first_req",  {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        check("first_ir",       IR, 32'h0050_0093);
        check("first_ir_pc",    ir_pc, 32'h100);
        check("first_ir_valid", {31'b0, ir_valid}, 32'd1);

        // Decoder stalls five cycles: IR frozen, no requests
        imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
        hold_ir = 32'h0050_0093;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_ir",    IR, hold_ir);
            check("hold_ir_pc", ir_pc, 32'h100);
            check("hold_valid", {31'b0, ir_valid}, 32'd1);
            check("hold_req",   {31'b0, imem_req}, 32'd0);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("next_addr",  imem_addr, 32'h104);
        check("next_req",   {31'b0, imem_req}, 32'd1);
        check("next_valid", {31'b0, ir_valid}, 32'd0);

        // Redirect to 0x200 while 0x104 is outstanding; ack after 3 cycles
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("drain_addr1", imem_addr, 32'h104);
        check("drain_req1",  {31'b0, imem_req}, 32'd1);
        tick();
        check("drain_addr2", imem_addr, 32'h104);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("drain_drop_valid", {31'b0, ir_valid}, 32'd0);
        check("drain_new_addr",   imem_addr, 32'h200);
        imem_rdata = 32'h1111_1111;
        tick();
        check("redir_ir",    IR, 32'h1111_1111);
        check("redir_ir_pc", ir_pc, 32'h200);
        check("redir_valid", {31'b0, ir_valid}, 32'd1);

        // Redirect coinciding with an ack in FETCH
        imem_ack = 1'b0; ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("pre_same_addr", imem_addr, 32'h204);
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        check("same_valid", {31'b0, ir_valid}, 32'd0);
        check("same_addr",  imem_addr, 32'h300);
        check("same_req",   {31'b0, imem_req}, 32'd1);
        tick();
        check("same_idle_valid", {31'b0, ir_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        check("same_ir",    IR, 32'h3333_3333);
        check("same_ir_pc", ir_pc, 32'h300);

        // Redirect from HOLD to the top word, then wrap past 2^32
`ifdef FETCH_MISALIGN_CHECK_EN
        wrap_rpc = 32'hFFFF_FFFC;
`else
        wrap_rpc = 32'hFFFF_FFFE;  // low bits ignored in this build
`endif
        imem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = wrap_rpc;
        tick();
        redirect = 1'b0;
        check("hold_redir_valid", {31'b0, ir_valid}, 32'd0);
        check("hold_redir_addr",  imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        tick();
        imem_ack = 1'b0;
        check("top_ir_pc", ir_pc, 32'hFFFF_FFFC);
        check("top_ir",    IR, 32'h4444_4444);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Two redirects while draining: only pc moves, stays in DRAIN
        redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_pc = 32'h500;
        tick();
        redirect = 1'b0;
        check("drain2_addr", imem_addr, 32'h0000_0000);
        check("drain2_req",  {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        check("drain2_valid",    {31'b0, ir_valid}, 32'd0);
        check("drain2_new_addr", imem_addr, 32'h500);
        tick();
        imem_ack = 1'b0;
        check("drain2_ir_pc", ir_pc, 32'h500);
        check("drain2_ir",    IR, 32'h5555_5555);

        // Reset in the middle of an outstanding request
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("pre_rst_addr", imem_addr, 32'h504);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("mid_rst_addr",  imem_addr, 32'h100);
        check("mid_rst_ir",    IR, 32'h0);
        check("mid_rst_ir_pc", ir_pc, 32'h0);
        check("mid_rst_valid", {31'b0, ir_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req", {31'b0, imem_req}, 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect from HOLD halts fetch; aligned redirect resumes
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect = 1'b0;
        check("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
        check("mis_bad",  fetch_bad_pc, 32'h202);
        check("mis_req",  {31'b0, imem_req}, 32'd0);
        tick();
        check("mis_req_stay", {31'b0, imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        check("mis_clear",     {31'b0, fetch_misaligned}, 32'd0);
        check("mis_new_addr",  imem_addr, 32'h300);
        check("mis_new_req",   {31'b0, imem_req}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
